// File: rtl/i2c_bus_arbiter.sv
// I2C bus monitor and two-requester round-robin arbiter.
// Tracks START/STOP, bus-free time and stuck-SCL timeout.
module i2c_bus_arbiter #(
    parameter int BUF_CYCLES     = 8,
    parameter int TIMEOUT_CYCLES = 1000,
    parameter int CW             = 10
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       scl_f,
    input  logic       sda_f,
    input  logic [1:0] req,
    output logic [1:0] gnt,
    output logic       bus_busy,
    output logic       bus_free,
    output logic       start_det,
    output logic       rstart_det,
    output logic       stop_det,
    output logic       timeout
);
    typedef enum logic [1:0] {
        ARB_IDLE,
        ARB_GRANT,
        ARB_RELEASE
    } arb_state_t;

    localparam logic [CW-1:0] BUF_MAX = CW'(BUF_CYCLES);
    localparam logic [CW-1:0] TO_LAST = CW'(TIMEOUT_CYCLES - 1);

    arb_state_t    state;
    logic          scl_q;
    logic          sda_q;
    logic [CW-1:0] free_cnt;
    logic [CW-1:0] to_cnt;
    logic          last_owner;
    logic          start_cond;
    logic          stop_cond;
    logic          free_clr;
    logic          to_hit;
    logic [1:0]    pick;

    // SCL must be stable high across the SDA edge for START/STOP
    assign start_cond = scl_q & scl_f & sda_q & ~sda_f;
    assign stop_cond  = scl_q & scl_f & ~sda_q & sda_f;
    assign free_clr   = ~scl_f | ~sda_f | bus_busy | start_cond | stop_cond;
    assign to_hit     = bus_busy & ~scl_f & (to_cnt == TO_LAST);

    always_comb begin
        pick = req;
        if (req == 2'b11)
            pick = last_owner ? 2'b01 : 2'b10;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            scl_q      <= 1'b1;
            sda_q      <= 1'b1;
            start_det  <= 1'b0;
            rstart_det <= 1'b0;
            stop_det   <= 1'b0;
            timeout    <= 1'b0;
            bus_busy   <= 1'b0;
            bus_free   <= 1'b0;
            free_cnt   <= '0;
            to_cnt     <= '0;
            gnt        <= 2'b00;
            last_owner <= 1'b1;
            state      <= ARB_IDLE;
        end else begin
            scl_q      <= scl_f;
            sda_q      <= sda_f;
            start_det  <= start_cond & ~bus_busy;
            rstart_det <= start_cond & bus_busy;
            stop_det   <= stop_cond;
            timeout    <= to_hit;

            if (to_hit || stop_cond)
                bus_busy <= 1'b0;
            else if (start_cond)
                bus_busy <= 1'b1;

            if (to_hit || scl_f || !bus_busy)
                to_cnt <= '0;
            else
                to_cnt <= to_cnt + 1'b1;

            if (free_clr)
                free_cnt <= '0;
            else if (free_cnt != BUF_MAX)
                free_cnt <= free_cnt + 1'b1;
            bus_free <= (free_cnt == BUF_MAX);

            unique case (state)
                ARB_IDLE: begin
                    if (bus_free && req != 2'b00) begin
                        gnt        <= pick;
                        last_owner <= pick[1];
                        state      <= ARB_GRANT;
                    end
                end
                ARB_GRANT: begin
                    if (to_hit) begin
                        gnt   <= 2'b00;
                        state <= ARB_IDLE;
                    end else if ((req & gnt) == 2'b00) begin
                        gnt   <= 2'b00;
                        state <= ARB_RELEASE;
                    end
                end
                ARB_RELEASE: begin
                    if (!bus_busy && bus_free)
                        state <= ARB_IDLE;
                end
                default: begin
                    gnt   <= 2'b00;
                    state <= ARB_IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_i2c_bus_arbiter.sv
// Directed bench for i2c_bus_arbiter: bus conditions, grants,
// timeout and reset recovery.
module tb_i2c_bus_arbiter;
    logic       clk = 1'b0;
    logic       rst;
    logic       scl_f;
    logic       sda_f;
    logic [1:0] req;
    logic [1:0] gnt;
    logic       bus_busy;
    logic       bus_free;
    logic       start_det;
    logic       rstart_det;
    logic       stop_det;
    logic       timeout;

    int checks   = 0;
    int failures = 0;
    int n;
    logic [1:0] gnt_prev = 2'b00;

    i2c_bus_arbiter dut (
        .clk        (clk),
        .rst        (rst),
        .scl_f      (scl_f),
        .sda_f      (sda_f),
        .req        (req),
        .gnt        (gnt),
        .bus_busy   (bus_busy),
        .bus_free   (bus_free),
        .start_det  (start_det),
        .rstart_det (rstart_det),
        .stop_det   (stop_det),
        .timeout    (timeout)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_gnt(input int max, output int cnt);
        cnt = 0;
        while (gnt == 2'b00 && cnt < max) begin
            step();
            cnt++;
        end
    endtask

    // gnt stays one-hot-or-zero and only changes through 00
    always @(negedge clk) begin
        if (!rst) begin
            check("gnt_inv",
                  {31'd0, ($onehot0(gnt) &&
                   (gnt_prev == 2'b00 || gnt == 2'b00 || gnt == gnt_prev))},
                  32'd1);
        end
        gnt_prev <= gnt;
    end

    initial begin
        rst   = 1'b1;
        scl_f = 1'b1;
        sda_f = 1'b1;
        req   = 2'b00;
        step();
        step();
        check("rst_gnt", gnt, 2'b00);
        check("rst_busy", bus_busy, 1'b0);
        check("rst_free", bus_free, 1'b0);
        check("rst_start", start_det, 1'b0);
        rst = 1'b0;

        // basic grant: bus_free after 8 idle cycles + register
        n = 0;
        repeat (2) begin step(); n++; end
        req = 2'b01;
        repeat (5) begin step(); n++; end
        check("free_early", bus_free, 1'b0);
        check("gnt_early", gnt, 2'b00);
        while (!bus_free && n < 30) begin step(); n++; end
        check("free_cycle", n, 9);
        check("gnt_at_free", gnt, 2'b00);
        step();
        check("gnt_first", gnt, 2'b01);

        // START
        sda_f = 1'b0;
        step();
        check("start_det", start_det, 1'b1);
        check("busy_set", bus_busy, 1'b1);
        step();
        check("start_pulse", start_det, 1'b0);
        check("free_drop", bus_free, 1'b0);

        // repeated START
        scl_f = 1'b0; step();
        sda_f = 1'b1; step();
        scl_f = 1'b1; step();
        sda_f = 1'b0; step();
        check("rstart_det", rstart_det, 1'b1);
        check("rstart_nostart", start_det, 1'b0);
        check("rstart_busy", bus_busy, 1'b1);
        step();
        check("rstart_pulse", rstart_det, 1'b0);

        // STOP
        scl_f = 1'b0; step();
        scl_f = 1'b1; step();
        check("no_stop_early", stop_det, 1'b0);
        sda_f = 1'b1; step();
        check("stop_det", stop_det, 1'b1);
        check("busy_clr", bus_busy, 1'b0);
        check("gnt_held", gnt, 2'b01);
        repeat (8) step();
        check("free_after8", bus_free, 1'b0);
        step();
        check("free_after9", bus_free, 1'b1);

        // non-owner request ignored, then round-robin handover
        req = 2'b11; step(); step();
        check("nonowner_ign", gnt, 2'b01);
        req = 2'b10; step();
        check("release_gnt", gnt, 2'b00);
        wait_gnt(10, n);
        check("rr_gnt", gnt, 2'b10);

        // stuck SCL timeout
        sda_f = 1'b0; step();
        check("to_busy", bus_busy, 1'b1);
        scl_f = 1'b0;
        n = 0;
        while (!timeout && n < 1100) begin step(); n++; end
        check("to_cycles", n, 1000);
        check("to_gnt", gnt, 2'b00);
        check("to_busy_clr", bus_busy, 1'b0);
        step();
        check("to_pulse", timeout, 1'b0);
        repeat (20) step();
        check("to_nogrant", gnt, 2'b00);
        scl_f = 1'b1;
        sda_f = 1'b1;
        repeat (8) step();
        check("to_wait", gnt, 2'b00);
        wait_gnt(10, n);
        check("to_regrant", gnt, 2'b10);

        // simultaneous SCL/SDA change is neither START nor STOP
        scl_f = 1'b0; sda_f = 1'b0; step();
        check("simul_nostart", start_det, 1'b0);
        check("simul_nobusy", bus_busy, 1'b0);
        scl_f = 1'b1; sda_f = 1'b1; step();
        check("simul_nostop", stop_det, 1'b0);

        // reset mid-transfer with gnt=10
        repeat (2) step();
        sda_f = 1'b0; step();
        check("mid_busy", bus_busy, 1'b1);
        check("mid_gnt", gnt, 2'b10);
        rst = 1'b1; step();
        check("mid_rst_gnt", gnt, 2'b00);
        check("mid_rst_busy", bus_busy, 1'b0);
        check("mid_rst_free", bus_free, 1'b0);
        rst   = 1'b0;
        sda_f = 1'b1;
        req   = 2'b11;
        wait_gnt(20, n);
        check("tie_after_rst", gnt, 2'b01);

        // tie with last owner 0 goes to requester 1
        req = 2'b00; step();
        check("drop_all", gnt, 2'b00);
        repeat (3) step();
        req = 2'b11;
        wait_gnt(10, n);
        check("tie_last0", gnt, 2'b10);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
